// File: rtl/cdb_arbiter_pkg.sv
// Shared FU result/CDB types and unit-count constants for the CDB arbiter.
// No logic; sizing of the request vector follows the unit counts below.
package cdb_arbiter_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 5;
  localparam int REG_IDX_W = 5;

  localparam int NUM_ALU_CMP_UNITS = 4;
  localparam int NUM_MULDIV_UNITS  = 0;
  localparam int NUM_LOAD_UNITS    = 0;

  localparam int NUM_CDB_REQ = NUM_ALU_CMP_UNITS + NUM_MULDIV_UNITS + NUM_LOAD_UNITS;
  localparam int NUM_CDB     = 2;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [REG_IDX_W-1:0] rd_addr;
    logic [XLEN-1:0]      rd_data;
  } fu_cdb_data_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-result request side and CDB broadcast side of the arbiter.
// master = FUs/consumers, slave = arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ   = cdb_arbiter_pkg::NUM_CDB_REQ,
  parameter int NUM_CDB = cdb_arbiter_pkg::NUM_CDB
) ();

  logic                branch_mispredict;
  logic [N_REQ-1:0]    fu_done;
  fu_cdb_data_t        fu_data [N_REQ];
  logic [N_REQ-1:0]    cdb_ack;
  logic [NUM_CDB-1:0]  cdb_valid;
  fu_cdb_data_t        cdb_data [NUM_CDB];

  modport master (
    output branch_mispredict, fu_done, fu_data,
    input  cdb_ack, cdb_valid, cdb_data
  );

  modport slave (
    input  branch_mispredict, fu_done, fu_data,
    output cdb_ack, cdb_valid, cdb_data
  );

endinterface

// File: rtl/cdb_arbiter_picker.sv
// Combinational round-robin picker: first NUM_CDB requesters scanning from ptr_i,
// k-th winner on slot k; next pointer is one past the last winner (holds if none).
module rr_multi_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int NUM_CDB = 2,
  localparam int PTR_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]   req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [N_REQ-1:0]   grant_oh_o  [NUM_CDB],
  output logic [PTR_W-1:0]   grant_idx_o [NUM_CDB],
  output logic [NUM_CDB-1:0] grant_vld_o,
  output logic [PTR_W-1:0]   nxt_ptr_o
);

  always_comb begin
    int cnt;
    int idx;
    int last;
    for (int k = 0; k < NUM_CDB; k++) begin
      grant_oh_o[k]  = '0;
      grant_idx_o[k] = '0;
    end
    grant_vld_o = '0;
    nxt_ptr_o   = ptr_i;
    cnt         = 0;
    idx         = 0;
    last        = 0;
    for (int o = 0; o < N_REQ; o++) begin
      idx = int'(ptr_i) + o;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (req_i[idx] && cnt < NUM_CDB) begin
        grant_oh_o[cnt][idx] = 1'b1;
        grant_idx_o[cnt]     = PTR_W'(idx);
        grant_vld_o[cnt]     = 1'b1;
        last                 = idx;
        cnt                  = cnt + 1;
      end
    end
    if (cnt > 0) begin
      nxt_ptr_o = PTR_W'(wrap_inc(last, N_REQ));
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: combinational acks in cycle t, registered broadcast in t+1.
// No stall path; flush drops grants and clears broadcast valids.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ   = cdb_arbiter_pkg::NUM_CDB_REQ,
  parameter int NUM_CDB = cdb_arbiter_pkg::NUM_CDB
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave cdb
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_CDB-1:0] cdb_valid_q, cdb_valid_d;
  fu_cdb_data_t       cdb_data_q [NUM_CDB];
  fu_cdb_data_t       cdb_data_d [NUM_CDB];

  logic [N_REQ-1:0]   grant_oh  [NUM_CDB];
  logic [PTR_W-1:0]   grant_idx [NUM_CDB];
  logic [NUM_CDB-1:0] grant_vld;
  logic [PTR_W-1:0]   nxt_ptr;
  logic               grant_en;
  logic [N_REQ-1:0]   ack_c;

  rr_multi_picker #(
    .N_REQ   (N_REQ),
    .NUM_CDB (NUM_CDB)
  ) u_picker (
    .req_i       (cdb.fu_done),
    .ptr_i       (rr_ptr_q),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld),
    .nxt_ptr_o   (nxt_ptr)
  );

  // Reset and flush both suppress the whole grant, including the pointer advance.
  assign grant_en = !rst && !cdb.branch_mispredict;

  always_comb begin
    ack_c = '0;
    if (grant_en) begin
      for (int k = 0; k < NUM_CDB; k++) begin
        ack_c = ack_c | grant_oh[k];
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = '0;
    cdb_data_d  = cdb_data_q;
    if (grant_en) begin
      rr_ptr_d = nxt_ptr;
      for (int k = 0; k < NUM_CDB; k++) begin
        if (grant_vld[k]) begin
          cdb_valid_d[k] = 1'b1;
          cdb_data_d[k]  = cdb.fu_data[grant_idx[k]];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_data_q[k] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  assign cdb.cdb_ack   = ack_c;
  assign cdb.cdb_valid = cdb_valid_q;
  assign cdb.cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and random checks of the CDB arbiter at N_REQ=4, NUM_CDB=2.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int NC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_REQ(NR), .NUM_CDB(NC)) bus ();

  cdb_arbiter #(.N_REQ(NR), .NUM_CDB(NC)) dut (
    .clk (clk),
    .rst (rst),
    .cdb (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic fu_cdb_data_t mk(input int i, input int tag);
    fu_cdb_data_t d;
    d.rob_idx = 5'(i + 1);
    d.rd_addr = 5'(tag);
    d.rd_data = 32'hC0DE_0000 + 32'(tag * 16 + i);
    return d;
  endfunction

  task automatic set_data(input int tag);
    for (int i = 0; i < NR; i++) bus.fu_data[i] = mk(i, tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_ack [4];
  int         exp_ptr [4];
  int         lo;

  // random-phase model state
  logic [3:0]   done, prev_ack, mack;
  logic [7:0]   dd;
  logic [1:0]   ev;
  fu_cdb_data_t ed [NC];
  int           mptr, n, last, pc, maxw;
  int           slot [NC];
  int           waitc [NR];
  logic         bm;

  initial begin
    bus.fu_done = '0;
    bus.branch_mispredict = 1'b0;
    set_data(1);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rst_ack", 64'(bus.cdb_ack), 64'(0));
    check("rst_valid", 64'(bus.cdb_valid), 64'(0));
    check("rst_data0", 64'(bus.cdb_data[0]), 64'(0));
    check("rst_ptr", 64'(dut.rr_ptr_q), 64'(0));
    tick();
    check("idle_valid", 64'(bus.cdb_valid), 64'(0));

    bus.fu_done = 4'b1111;
    #1;
    check("first_ack", 64'(bus.cdb_ack), 64'(4'b0011));
    tick();
    check("first_valid", 64'(bus.cdb_valid), 64'(2'b11));
    check("first_data0", 64'(bus.cdb_data[0]), 64'(mk(0, 1)));
    check("first_data1", 64'(bus.cdb_data[1]), 64'(mk(1, 1)));
    check("first_ptr", 64'(dut.rr_ptr_q), 64'(2));
    #1;
    check("pre_rst_ack", 64'(bus.cdb_ack), 64'(4'b1100));
    #1 rst = 1'b1;
    #1;
    check("midrst_ack", 64'(bus.cdb_ack), 64'(0));
    check("midrst_valid", 64'(bus.cdb_valid), 64'(0));
    check("midrst_data1", 64'(bus.cdb_data[1]), 64'(0));
    check("midrst_ptr", 64'(dut.rr_ptr_q), 64'(0));
    rst = 1'b0;
    #1;

    exp_ack = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    exp_ptr = '{2, 0, 2, 0};
    for (int j = 0; j < 4; j++) begin
      lo = (j % 2) * 2;
      check("cont_ack", 64'(bus.cdb_ack), 64'(exp_ack[j]));
      tick();
      check("cont_valid", 64'(bus.cdb_valid), 64'(2'b11));
      check("cont_data0", 64'(bus.cdb_data[0]), 64'(mk(lo, 1)));
      check("cont_data1", 64'(bus.cdb_data[1]), 64'(mk(lo + 1, 1)));
      check("cont_ptr", 64'(dut.rr_ptr_q), 64'(exp_ptr[j]));
    end

    set_data(2);
    bus.fu_done = 4'b0100;
    #1;
    check("single_ack", 64'(bus.cdb_ack), 64'(4'b0100));
    tick();
    check("single_valid", 64'(bus.cdb_valid), 64'(2'b01));
    check("single_data0", 64'(bus.cdb_data[0]), 64'(mk(2, 2)));
    check("single_data1_hold", 64'(bus.cdb_data[1]), 64'(mk(3, 1)));
    check("single_ptr", 64'(dut.rr_ptr_q), 64'(3));

    bus.fu_done = 4'b1001;
    #1;
    check("wrap_ack", 64'(bus.cdb_ack), 64'(4'b1001));
    tick();
    check("wrap_valid", 64'(bus.cdb_valid), 64'(2'b11));
    check("wrap_data0", 64'(bus.cdb_data[0]), 64'(mk(3, 2)));
    check("wrap_data1", 64'(bus.cdb_data[1]), 64'(mk(0, 2)));
    check("wrap_ptr", 64'(dut.rr_ptr_q), 64'(1));

    bus.fu_done = 4'b0110;
    bus.branch_mispredict = 1'b1;
    #1;
    check("flush_ack", 64'(bus.cdb_ack), 64'(0));
    check("flush_prev_visible", 64'(bus.cdb_valid), 64'(2'b11));
    tick();
    check("flush_valid", 64'(bus.cdb_valid), 64'(0));
    check("flush_ptr", 64'(dut.rr_ptr_q), 64'(1));
    bus.branch_mispredict = 1'b0;
    #1;
    check("postflush_ack", 64'(bus.cdb_ack), 64'(4'b0110));
    tick();
    check("postflush_valid", 64'(bus.cdb_valid), 64'(2'b11));
    check("postflush_data0", 64'(bus.cdb_data[0]), 64'(mk(1, 2)));
    check("postflush_data1", 64'(bus.cdb_data[1]), 64'(mk(2, 2)));
    check("postflush_ptr", 64'(dut.rr_ptr_q), 64'(3));

    bus.fu_done = 4'b0000;
    #1;
    check("zero_ack", 64'(bus.cdb_ack), 64'(0));
    tick();
    check("zero_valid", 64'(bus.cdb_valid), 64'(0));
    check("zero_ptr", 64'(dut.rr_ptr_q), 64'(3));
    check("zero_data0_hold", 64'(bus.cdb_data[0]), 64'(mk(1, 2)));

    // Random phase: FUs hold requests until acked; bench keeps its own arbiter model.
    rst = 1'b1;
    #1 rst = 1'b0;
    mptr = 0;
    ev = '0;
    for (int k = 0; k < NC; k++) ed[k] = '0;
    prev_ack = '0;
    maxw = 0;
    for (int i = 0; i < NR; i++) waitc[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      check("rnd_valid", 64'(bus.cdb_valid), 64'(ev));
      for (int k = 0; k < NC; k++) check("rnd_data", 64'(bus.cdb_data[k]), 64'(ed[k]));
      for (int i = 0; i < NR; i++) begin
        if (prev_ack[i] || !bus.fu_done[i]) begin
          bus.fu_done[i] = ($urandom_range(0, 2) != 0);
          if (bus.fu_done[i]) bus.fu_data[i] = mk(i, c % 32);
        end
      end
      bm = ($urandom_range(0, 15) == 0);
      bus.branch_mispredict = bm;
      #1;
      done = bus.fu_done;
      dd = {done, done} >> mptr;
      mack = '0;
      n = 0;
      last = 0;
      for (int p = 0; p < NR; p++) begin
        if (dd[p] && n < NC) begin
          slot[n] = (mptr + p) % NR;
          mack[slot[n]] = 1'b1;
          last = slot[n];
          n++;
        end
      end
      if (bm) mack = '0;
      pc = $countones(done);
      check("rnd_ack", 64'(bus.cdb_ack), 64'(mack));
      check("rnd_ack_subset", 64'(bus.cdb_ack & ~done), 64'(0));
      check("rnd_ack_count", 64'($countones(bus.cdb_ack)), 64'(bm ? 0 : (pc < NC ? pc : NC)));
      ev = '0;
      if (!bm) begin
        for (int k = 0; k < n; k++) begin
          ev[k] = 1'b1;
          ed[k] = bus.fu_data[slot[k]];
        end
        if (n > 0) mptr = (last + 1) % NR;
      end
      for (int i = 0; i < NR; i++) begin
        if (done[i] && !bus.cdb_ack[i] && !bm) waitc[i]++;
        else if (!done[i] || bus.cdb_ack[i]) waitc[i] = 0;
        if (waitc[i] > maxw) maxw = waitc[i];
      end
      prev_ack = bus.cdb_ack;
    end
    check("rnd_max_wait_le2", 64'(maxw <= 2), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
